// File: rtl/data_bus_router.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_router
// Description : Single-initiator data-bus interconnect. Decodes the SoC memory
//               map, forwards a core request to exactly one of eight slaves
//               (ROM, CODE, DATA, GPIO, SPI, UART, TIMER, PMC) and returns its
//               response. Unmapped addresses are answered by an internal
//               error responder. One outstanding transaction at a time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : WAIT_RSP is bounded; a silent slave yields an error response
//               TIMEOUT_CYC cycles after the grant.
//   undefined : WAIT_RSP waits indefinitely for the selected slave.
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   m_req_i         initiator request
//   m_gnt_o         request accepted (combinational, IDLE only)
//   m_addr_i        byte address
//   m_we_i          1 = write
//   m_be_i          byte enables
//   m_wdata_i       write data
//   m_rvalid_o      one-cycle response strobe per granted request
//   m_rdata_o       read data (ERR_RDATA on error, 0 on write)
//   m_err_o         error flag, qualified by m_rvalid_o
//   s_req_o         per-slave request, one-hot or zero
//   s_gnt_i         per-slave grant
//   s_addr_o/s_we_o/s_be_o/s_wdata_o   broadcast of the initiator fields
//   s_rvalid_i      per-slave response valid
//   s_rdata_i       slave i read data at [32*i+31:32*i]
//   s_err_i         per-slave error
// ============================================================================
module data_bus_router #(
  parameter int          NUM_SLAVES  = 8,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  // initiator side
  input  logic                     m_req_i,
  output logic                     m_gnt_o,
  input  logic [31:0]              m_addr_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  logic [31:0]              m_wdata_i,
  output logic                     m_rvalid_o,
  output logic [31:0]              m_rdata_o,
  output logic                     m_err_o,
  // slave side
  output logic [NUM_SLAVES-1:0]    s_req_o,
  input  logic [NUM_SLAVES-1:0]    s_gnt_i,
  output logic [31:0]              s_addr_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output logic [31:0]              s_wdata_o,
  input  logic [NUM_SLAVES-1:0]    s_rvalid_i,
  input  logic [NUM_SLAVES*32-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic       we_q, we_d;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic       hit;
  logic [2:0] idx;

  always_comb begin
    hit = 1'b1;
    idx = 3'd0;
    if (m_addr_i[31:12] == 20'h00000)      idx = 3'd0; // ROM   0x0000_0000-0FFF
    else if (m_addr_i[31:14] == 18'h00004) idx = 3'd1; // CODE  0x0001_0000-3FFF
    else if (m_addr_i[31:14] == 18'h00040) idx = 3'd2; // DATA  0x0010_0000-3FFF
    else if (m_addr_i[31:12] == 20'h01000) idx = 3'd3; // GPIO  0x0100_0xxx
    else if (m_addr_i[31:12] == 20'h01001) idx = 3'd4; // SPI   0x0100_1xxx
    else if (m_addr_i[31:12] == 20'h01002) idx = 3'd5; // UART  0x0100_2xxx
    else if (m_addr_i[31:12] == 20'h01003) idx = 3'd6; // TIMER 0x0100_3xxx
    else if (m_addr_i[31:16] == 16'h0101)  idx = 3'd7; // PMC   0x0101_xxxx
    else                                   hit = 1'b0;
  end

  // Request fields go to every slave; only s_req_o qualifies them.
  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  // Response of the slave latched at grant time.
  logic        sel_rvalid;
  logic        sel_err;
  logic [31:0] sel_rdata;

  assign sel_rvalid = s_rvalid_i[sel_q];
  assign sel_err    = s_err_i[sel_q];
  assign sel_rdata  = s_rdata_i[32*sel_q +: 32];

  // --------------------------------------------------------------------------
  // Optional response timeout
  // --------------------------------------------------------------------------
  logic timeout;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter reads 0 in the first WAIT_RSP cycle. Firing when the value
  // about to be written is TIMEOUT_CYC-1 places the error strobe exactly
  // TIMEOUT_CYC cycles after the grant cycle.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_RSP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    m_gnt_o    = 1'b0;
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    s_req_o    = '0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          s_req_o[idx] = m_req_i;
          m_gnt_o      = m_req_i & s_gnt_i[idx];
          if (m_req_i && s_gnt_i[idx]) begin
            sel_d   = idx;
            we_d    = m_we_i;
            state_d = WAIT_RSP;
          end
        end else begin
          // Internal default responder always accepts immediately.
          m_gnt_o = m_req_i;
          if (m_req_i) begin
            state_d = ERR_RSP;
          end
        end
      end

      WAIT_RSP: begin
        // Responses from any other slave are ignored.
        if (sel_rvalid) begin
          m_rvalid_o = 1'b1;
          m_err_o    = sel_err;
          if (sel_err) begin
            m_rdata_o = ERR_RDATA;
          end else if (!we_q) begin
            m_rdata_o = sel_rdata;
          end
          state_d = IDLE;
        end else if (timeout) begin
          state_d = ERR_RSP;
        end
      end

      ERR_RSP: begin
        m_rvalid_o = 1'b1;
        m_err_o    = 1'b1;
        m_rdata_o  = ERR_RDATA;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_router
// Description : Self-checking bench for data_bus_router. Table of single
//               transactions plus hand-written multi-cycle corner cases; a
//               response scoreboard checks every m_rvalid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_router;

  logic         clk;
  logic         rst;
  logic         m_req_i;
  logic         m_gnt_o;
  logic [31:0]  m_addr_i;
  logic         m_we_i;
  logic [3:0]   m_be_i;
  logic [31:0]  m_wdata_i;
  logic         m_rvalid_o;
  logic [31:0]  m_rdata_o;
  logic         m_err_o;
  logic [7:0]   s_req_o;
  logic [7:0]   s_gnt_i;
  logic [31:0]  s_addr_o;
  logic         s_we_o;
  logic [3:0]   s_be_o;
  logic [31:0]  s_wdata_o;
  logic [7:0]   s_rvalid_i;
  logic [255:0] s_rdata_i;
  logic [7:0]   s_err_i;

  data_bus_router dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .m_err_o    (m_err_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .s_err_i    (s_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Response scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  always @(negedge clk) begin : mon
    rsp_t e;
    if (m_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got m_rvalid=1 rdata=%h, expected no response", m_rdata_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", m_rdata_o, e.rdata);
        chk("rsp_err", 32'(m_err_o), 32'(e.err));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          idx;       // 8 = unmapped
    logic [7:0]  exp_sreq;
    int          gnt_dly;
    int          rsp_dly;
    logic [31:0] srdata;
    logic        serr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic do_txn(input vec_t v);
    logic mapped;
    mapped    = (v.idx < 8);
    m_addr_i  = v.addr;
    m_we_i    = v.we;
    m_be_i    = 4'hF;
    m_wdata_i = v.wdata;
    m_req_i   = 1'b1;
    for (int c = 0; c < v.gnt_dly; c++) begin
      // a grant from some other slave must not be forwarded
      s_gnt_i = 8'h1 << ((v.idx + 1) % 8);
      @(negedge clk);
      chk("gnt_wait", 32'(m_gnt_o), 32'd0);
      chk("sreq_wait", 32'(s_req_o), 32'(v.exp_sreq));
      @(posedge clk); #1;
    end
    s_gnt_i = mapped ? (8'h1 << v.idx) : 8'h00;
    @(negedge clk);
    chk("gnt", 32'(m_gnt_o), 32'd1);
    chk("sreq", 32'(s_req_o), 32'(v.exp_sreq));
    chk("s_addr", s_addr_o, v.addr);
    exp_q.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk); #1;
    m_req_i = 1'b0;
    s_gnt_i = 8'h00;
    if (mapped) begin
      for (int c = 0; c < v.rsp_dly; c++) begin
        @(negedge clk);
        chk("rvalid_early", 32'(m_rvalid_o), 32'd0);
        @(posedge clk); #1;
      end
      s_rvalid_i                  = 8'h1 << v.idx;
      s_err_i                     = v.serr ? (8'h1 << v.idx) : 8'h00;
      s_rdata_i[v.idx*32 +: 32]   = v.srdata;
      @(negedge clk);
      @(posedge clk); #1;
      s_rvalid_i = 8'h00;
      s_err_i    = 8'h00;
      s_rdata_i  = '0;
    end else begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rsp_pending", 32'(exp_q.size()), 32'd0);
    chk("rvalid_after", 32'(m_rvalid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat;

  initial begin
    rst        = 1'b1;
    m_req_i    = 1'b0;
    m_addr_i   = '0;
    m_we_i     = 1'b0;
    m_be_i     = '0;
    m_wdata_i  = '0;
    s_gnt_i    = '0;
    s_rvalid_i = '0;
    s_rdata_i  = '0;
    s_err_i    = '0;

    //          addr          we    wdata         idx sreq  gd rd srdata        serr  exp_rdata     exp_err
    vecs[0]  = '{32'h0010_0004, 1'b0, 32'h0,        2, 8'h04, 0, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[1]  = '{32'h0100_2000, 1'b1, 32'h0000_0041, 5, 8'h20, 3, 1, 32'hAAAA_5555, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{32'h0200_0000, 1'b0, 32'h0,        8, 8'h00, 0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{32'h0000_0FFC, 1'b0, 32'h0,        0, 8'h01, 0, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[4]  = '{32'h0000_1000, 1'b0, 32'h0,        8, 8'h00, 0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{32'h0001_3FFC, 1'b0, 32'h0,        1, 8'h02, 1, 2, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b0};
    vecs[6]  = '{32'h0001_4000, 1'b1, 32'h1111_1111, 8, 8'h00, 0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[7]  = '{32'h0100_1008, 1'b0, 32'h0,        4, 8'h10, 0, 0, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{32'h0100_3004, 1'b0, 32'h0,        6, 8'h40, 0, 3, 32'h0000_0042, 1'b0, 32'h0000_0042, 1'b0};
    vecs[9]  = '{32'h0101_FFFC, 1'b1, 32'h5555_AAAA, 7, 8'h80, 2, 0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h0100_0000, 1'b0, 32'h0,        3, 8'h08, 0, 0, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 1'b0};
    vecs[11] = '{32'h0100_4000, 1'b0, 32'h0,        8, 8'h00, 0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[12] = '{32'h0010_4000, 1'b0, 32'h0,        8, 8'h00, 0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", 32'(m_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(m_rvalid_o), 32'd0);
    chk("rst_rdata", m_rdata_o, 32'd0);
    chk("rst_err", 32'(m_err_o), 32'd0);
    chk("rst_sreq", 32'(s_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- table ----------------
    for (int i = 0; i < 13; i++) begin
      do_txn(vecs[i]);
    end

    // ---------------- spurious rvalid during WAIT_RSP on GPIO ----------------
    m_addr_i = 32'h0100_0010;
    m_we_i   = 1'b0;
    m_req_i  = 1'b1;
    s_gnt_i  = 8'h08;
    @(negedge clk);
    chk("gpio_gnt", 32'(m_gnt_o), 32'd1);
    exp_q.push_back('{32'h7777_0001, 1'b0});
    @(posedge clk); #1;
    m_addr_i          = 32'h0010_0000;
    s_gnt_i           = 8'hFF;
    s_rvalid_i        = 8'h20;
    s_rdata_i[5*32 +: 32] = 32'hBAD0_0005;
    @(negedge clk);
    chk("spur_rvalid", 32'(m_rvalid_o), 32'd0);
    chk("spur_gnt", 32'(m_gnt_o), 32'd0);
    chk("spur_sreq", 32'(s_req_o), 32'd0);
    @(posedge clk); #1;
    m_req_i               = 1'b0;
    s_gnt_i               = 8'h00;
    s_rvalid_i            = 8'h08;
    s_rdata_i             = '0;
    s_rdata_i[3*32 +: 32] = 32'h7777_0001;
    @(negedge clk);
    @(posedge clk); #1;
    s_rvalid_i = 8'h00;
    s_rdata_i  = '0;
    @(negedge clk);
    chk("spur_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // ---------------- reset while in WAIT_RSP ----------------
    m_addr_i = 32'h0010_0008;
    m_req_i  = 1'b1;
    s_gnt_i  = 8'h04;
    @(negedge clk);
    chk("rstw_gnt", 32'(m_gnt_o), 32'd1);
    @(posedge clk); #1;
    m_req_i = 1'b0;
    s_gnt_i = 8'h00;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_rvalid", 32'(m_rvalid_o), 32'd0);
    chk("rstw_gnt0", 32'(m_gnt_o), 32'd0);
    chk("rstw_sreq", 32'(s_req_o), 32'd0);
    chk("rstw_rdata", m_rdata_o, 32'd0);
    @(posedge clk); #1;
    s_rvalid_i            = 8'h04;
    s_rdata_i[2*32 +: 32] = 32'h0BAD_0002;
    @(negedge clk);
    chk("rstw_late_rvalid", 32'(m_rvalid_o), 32'd0);
    @(posedge clk); #1;
    s_rvalid_i = 8'h00;
    s_rdata_i  = '0;

    // ---------------- request withdrawn before grant ----------------
    m_addr_i = 32'h0100_1000;
    m_req_i  = 1'b1;
    @(negedge clk);
    chk("drop_sreq", 32'(s_req_o), 32'h10);
    chk("drop_gnt", 32'(m_gnt_o), 32'd0);
    @(posedge clk); #1;
    m_req_i = 1'b0;
    @(negedge clk);
    chk("drop_sreq0", 32'(s_req_o), 32'd0);
    @(posedge clk); #1;
    s_rvalid_i = 8'h10;
    @(negedge clk);
    chk("idle_rvalid", 32'(m_rvalid_o), 32'd0);
    @(posedge clk); #1;
    s_rvalid_i = 8'h00;
    do_txn(vecs[0]);

    // ---------------- PMC silent for a long time ----------------
    m_addr_i = 32'h0101_0000;
    m_we_i   = 1'b0;
    m_req_i  = 1'b1;
    s_gnt_i  = 8'h80;
    @(negedge clk);
    chk("pmc_gnt", 32'(m_gnt_o), 32'd1);
`ifdef BUS_TIMEOUT_EN
    exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
`else
    exp_q.push_back('{32'h0000_00AA, 1'b0});
`endif
    @(posedge clk); #1;
    m_req_i = 1'b0;
    s_gnt_i = 8'h00;
    lat     = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (m_rvalid_o === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
`ifdef BUS_TIMEOUT_EN
    chk("timeout_latency", 32'(lat), 32'd64);
    @(posedge clk); #1;
    s_rvalid_i            = 8'h80;
    s_rdata_i[7*32 +: 32] = 32'h0BAD_0007;
    @(negedge clk);
    chk("timeout_late_rvalid", 32'(m_rvalid_o), 32'd0);
    @(posedge clk); #1;
`else
    chk("no_timeout", 32'(lat), 32'd0);
    s_rvalid_i            = 8'h80;
    s_rdata_i[7*32 +: 32] = 32'h0000_00AA;
    @(negedge clk);
    @(posedge clk); #1;
`endif
    s_rvalid_i = 8'h00;
    s_rdata_i  = '0;
    @(negedge clk);
    chk("pmc_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
